idex_stage: RTL and testbench

IDEX_STAGE -- requirements
Module: idex_stage

---
 rtl/idex_stage.sv | 126 ++++++++++++
 tb/tb_idex_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_stage.sv
// ID/EX pipeline register with the EX-side operand forwarding, operand select,
// destination select and ALU control decode.
module idex_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        flush,
    input  logic        d_valid,
    input  logic [31:0] d_rd1,
    input  logic [31:0] d_rd2,
    input  logic [31:0] d_imm,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [4:0]  d_rd,
    input  logic [6:0]  d_ctrl,
    input  logic [5:0]  d_funct,
    input  logic        m_regwrite,
    input  logic [4:0]  m_writereg,
    input  logic [31:0] m_aluout,
    input  logic        w_regwrite,
    input  logic [4:0]  w_writereg,
    input  logic [31:0] w_result,
    output logic [31:0] srca,
    output logic [31:0] srcb,
    output logic [2:0]  alucontrol,
    output logic [31:0] e_writedata,
    output logic [4:0]  e_writereg,
    output logic [2:0]  e_ctrl,
    output logic        e_valid,
    output logic        e_illegal
);

    // r_ctrl = {regwrite, memtoreg, memwrite, alusrc, regdst, aluop[1:0]}
    localparam int C_ALUSRC = 3;
    localparam int C_REGDST = 2;

    logic        r_valid;
    logic [6:0]  r_ctrl;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [31:0] r_imm;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [5:0]  r_funct;

    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic [2:0]  w_alu;
    logic        w_bad;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_funct <= '0;
        end else if (flush) begin
            // Bubble: only validity and control are cleared, data is left as is.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (!stall) begin
            r_valid <= d_valid;
            r_ctrl  <= d_ctrl;
            r_rd1   <= d_rd1;
            r_rd2   <= d_rd2;
            r_imm   <= d_imm;
            r_rs    <= d_rs;
            r_rt    <= d_rt;
            r_rd    <= d_rd;
            r_funct <= d_funct;
        end
    end

    // MEM is checked last so it overrides WB as the more recent producer.
    always_comb begin
        w_fwd_a = r_rd1;
        if (w_regwrite && (w_writereg == r_rs) && (r_rs != 5'd0))
            w_fwd_a = w_result;
        if (m_regwrite && (m_writereg == r_rs) && (r_rs != 5'd0))
            w_fwd_a = m_aluout;
    end

    always_comb begin
        w_fwd_b = r_rd2;
        if (w_regwrite && (w_writereg == r_rt) && (r_rt != 5'd0))
            w_fwd_b = w_result;
        if (m_regwrite && (m_writereg == r_rt) && (r_rt != 5'd0))
            w_fwd_b = m_aluout;
    end

    always_comb begin
        w_alu = 3'd2;
        w_bad = 1'b0;
        case (r_ctrl[1:0])
            2'b00: w_alu = 3'd2;
            2'b01: w_alu = 3'd6;
            2'b10: begin
                case (r_funct)
                    6'h20:   w_alu = 3'd2;
                    6'h22:   w_alu = 3'd6;
                    6'h24:   w_alu = 3'd0;
                    6'h25:   w_alu = 3'd1;
                    6'h2A:   w_alu = 3'd7;
                    default: w_bad = 1'b1;
                endcase
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign srca        = w_fwd_a;
    assign srcb        = r_ctrl[C_ALUSRC] ? r_imm : w_fwd_b;
    assign e_writedata = w_fwd_b;
    assign e_writereg  = r_ctrl[C_REGDST] ? r_rd : r_rt;
    assign alucontrol  = w_alu;
    assign e_ctrl      = r_valid ? r_ctrl[6:4] : 3'b000;
    assign e_valid     = r_valid;
    assign e_illegal   = r_valid & w_bad;

endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: directed cases with literal expectations plus a long
// randomized run compared every cycle against a behavioural model.
module tb_idex_stage;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        flush;
    logic        d_valid;
    logic [31:0] d_rd1;
    logic [31:0] d_rd2;
    logic [31:0] d_imm;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [4:0]  d_rd;
    logic [6:0]  d_ctrl;
    logic [5:0]  d_funct;
    logic        m_regwrite;
    logic [4:0]  m_writereg;
    logic [31:0] m_aluout;
    logic        w_regwrite;
    logic [4:0]  w_writereg;
    logic [31:0] w_result;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [2:0]  alucontrol;
    logic [31:0] e_writedata;
    logic [4:0]  e_writereg;
    logic [2:0]  e_ctrl;
    logic        e_valid;
    logic        e_illegal;

    idex_stage dut (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .d_valid(d_valid), .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm),
        .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .d_ctrl(d_ctrl), .d_funct(d_funct),
        .m_regwrite(m_regwrite), .m_writereg(m_writereg), .m_aluout(m_aluout),
        .w_regwrite(w_regwrite), .w_writereg(w_writereg), .w_result(w_result),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol),
        .e_writedata(e_writedata), .e_writereg(e_writereg), .e_ctrl(e_ctrl),
        .e_valid(e_valid), .e_illegal(e_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    // Model of what the EX slot holds; dk = data fields are defined.
    typedef struct {
        logic        v;
        logic        dk;
        logic [6:0]  c;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fn;
    } ex_t;
    ex_t mdl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] regval);
        if (r == 5'd0) return regval;
        if (m_regwrite && m_writereg == r) return m_aluout;
        if (w_regwrite && w_writereg == r) return w_result;
        return regval;
    endfunction

    function automatic logic [3:0] exp_alu(input logic [1:0] op, input logic [5:0] fn);
        // returns {illegal, alucontrol}
        if (op == 2'd0) return {1'b0, 3'd2};
        if (op == 2'd1) return {1'b0, 3'd6};
        if (op == 2'd3) return {1'b1, 3'd2};
        if (fn == 6'h20) return {1'b0, 3'd2};
        if (fn == 6'h22) return {1'b0, 3'd6};
        if (fn == 6'h24) return {1'b0, 3'd0};
        if (fn == 6'h25) return {1'b0, 3'd1};
        if (fn == 6'h2A) return {1'b0, 3'd7};
        return {1'b1, 3'd2};
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mdl.v <= 1'b0; mdl.dk <= 1'b1; mdl.c <= '0;
            mdl.rd1 <= '0; mdl.rd2 <= '0; mdl.imm <= '0;
            mdl.rs <= '0; mdl.rt <= '0; mdl.rd <= '0; mdl.fn <= '0;
        end else if (flush) begin
            mdl.v <= 1'b0; mdl.dk <= 1'b0; mdl.c <= '0;
        end else if (!stall) begin
            mdl.v <= d_valid; mdl.dk <= 1'b1; mdl.c <= d_ctrl;
            mdl.rd1 <= d_rd1; mdl.rd2 <= d_rd2; mdl.imm <= d_imm;
            mdl.rs <= d_rs; mdl.rt <= d_rt; mdl.rd <= d_rd; mdl.fn <= d_funct;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [3:0]  ea;
            logic [31:0] fb;
            ea = exp_alu(mdl.c[1:0], mdl.fn);
            chk("cmp_valid", 32'(e_valid), 32'(mdl.v));
            chk("cmp_ctrl", 32'(e_ctrl), mdl.v ? 32'(mdl.c[6:4]) : 32'd0);
            chk("cmp_illegal", 32'(e_illegal), 32'(ea[3] & mdl.v));
            chk("cmp_alucontrol", 32'(alucontrol), 32'(ea[2:0]));
            if (mdl.dk) begin
                fb = fwd(mdl.rt, mdl.rd2);
                chk("cmp_srca", srca, fwd(mdl.rs, mdl.rd1));
                chk("cmp_srcb", srcb, mdl.c[3] ? mdl.imm : fb);
                chk("cmp_writedata", e_writedata, fb);
                chk("cmp_writereg", 32'(e_writereg), mdl.c[2] ? 32'(mdl.rd) : 32'(mdl.rt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] legal_fn [5];

    initial begin
        legal_fn[0] = 6'h20; legal_fn[1] = 6'h22; legal_fn[2] = 6'h24;
        legal_fn[3] = 6'h25; legal_fn[4] = 6'h2A;
        clk = 0; resetn = 0; stall = 0; flush = 0; d_valid = 0;
        d_rd1 = 0; d_rd2 = 0; d_imm = 0; d_rs = 0; d_rt = 0; d_rd = 0;
        d_ctrl = 0; d_funct = 0;
        m_regwrite = 0; m_writereg = 0; m_aluout = 0;
        w_regwrite = 0; w_writereg = 0; w_result = 0;
        repeat (2) tick();
        cmp_en = 1'b1;

        chk("rst_valid", 32'(e_valid), 32'd0);
        chk("rst_ctrl", 32'(e_ctrl), 32'd0);
        chk("rst_illegal", 32'(e_illegal), 32'd0);
        chk("rst_alucontrol", 32'(alucontrol), 32'd2);
        chk("rst_srca", srca, 32'd0);
        chk("rst_srcb", srcb, 32'd0);
        resetn = 1;

        // R-type add, no forwarding
        d_valid = 1; d_rd1 = 5; d_rd2 = 7; d_funct = 6'h20; d_ctrl = 7'b1000110;
        d_rs = 1; d_rt = 2; d_rd = 3;
        tick();
        chk("add_srca", srca, 32'd5);
        chk("add_srcb", srcb, 32'd7);
        chk("add_alu", 32'(alucontrol), 32'd2);
        chk("add_valid", 32'(e_valid), 32'd1);
        chk("add_writereg", 32'(e_writereg), 32'd3);

        // double hazard on rs
        d_rs = 3; d_rd1 = 32'h11;
        tick();
        m_regwrite = 1; m_writereg = 3; m_aluout = 32'hAA;
        w_regwrite = 1; w_writereg = 3; w_result = 32'hBB;
        #1 chk("hz_mem_wins", srca, 32'hAA);
        m_regwrite = 0;
        #1 chk("hz_wb", srca, 32'hBB);
        w_regwrite = 0;
        #1 chk("hz_none", srca, 32'h11);

        // register 0 never forwarded
        d_rs = 0; d_rd1 = 0;
        tick();
        m_regwrite = 1; m_writereg = 0; m_aluout = 32'hFF;
        #1 chk("zero_reg", srca, 32'd0);
        m_regwrite = 0;

        // immediate path, regdst=0
        d_ctrl = 7'b1001000; d_imm = 32'hFFFFFFFC; d_rt = 9; d_rd = 4;
        tick();
        chk("imm_srcb", srcb, 32'hFFFFFFFC);
        chk("imm_alu", 32'(alucontrol), 32'd2);
        chk("imm_writereg", 32'(e_writereg), 32'd9);

        // stall holds two cycles, then flush beats stall
        d_ctrl = 7'b1010110; d_funct = 6'h20; d_rs = 5; d_rd1 = 32'h1234;
        tick();
        chk("pri_ctrl", 32'(e_ctrl), 32'b101);
        stall = 1; d_valid = 0; d_ctrl = 0; d_rd1 = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_valid", 32'(e_valid), 32'd1);
            chk("stall_ctrl", 32'(e_ctrl), 32'b101);
            chk("stall_srca", srca, 32'h1234);
        end
        flush = 1;
        tick();
        chk("flush_valid", 32'(e_valid), 32'd0);
        chk("flush_ctrl", 32'(e_ctrl), 32'd0);
        stall = 0; flush = 0;

        // illegal funct, then async reset mid-stall
        d_valid = 1; d_ctrl = 7'b1000110; d_funct = 6'h3F;
        tick();
        chk("ill_flag", 32'(e_illegal), 32'd1);
        chk("ill_alu", 32'(alucontrol), 32'd2);
        stall = 1;
        #2 resetn = 0;
        #1 chk("ill_async_clr", 32'(e_illegal), 32'd0);
        chk("ill_async_valid", 32'(e_valid), 32'd0);
        tick();
        resetn = 1; stall = 0; d_funct = 6'h22;
        tick();
        chk("post_rst_load", 32'(e_valid), 32'd1);
        chk("post_rst_alu", 32'(alucontrol), 32'd6);

        for (int n = 0; n < 2000; n++) begin
            stall   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 7) == 0);
            d_valid = 1'($urandom);
            d_rd1   = $urandom; d_rd2 = $urandom; d_imm = $urandom;
            d_rs    = 5'($urandom_range(0, 3));
            d_rt    = 5'($urandom_range(0, 3));
            d_rd    = 5'($urandom);
            d_ctrl  = 7'($urandom);
            d_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
            m_regwrite = 1'($urandom); m_writereg = 5'($urandom_range(0, 3)); m_aluout = $urandom;
            w_regwrite = 1'($urandom); w_writereg = 5'($urandom_range(0, 3)); w_result = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                resetn = 0;
                tick();
                resetn = 1;
            end else begin
                tick();
            end
        end
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
